// File: rtl/serial_ripple_subtractor.sv
// -----------------------------------------------------------------------------
// serial_ripple_subtractor
//
// Bit-serial subtractor: D = A - B - Bin, one bit per clock, LSB first, with a
// single borrow flip-flop. Operands enter through a valid/ready port and the
// result leaves through a valid/ready port. The operand format matches the
// combinational ripple-carry adder (A, B, 1-bit carry/borrow-in).
//
// Optional feature: define SUB_OVF_EN to add the signed-overflow output ovf.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous reset, active-low
//   in_valid   operands a, b, bin valid
//   in_ready   block can accept operands (high in IDLE)
//   a          minuend, WIDTH bits
//   b          subtrahend, WIDTH bits
//   bin        borrow-in
//   out_valid  d, bout valid (high in DONE)
//   out_ready  consumer accepts the result
//   d          difference, WIDTH bits
//   bout       borrow-out, 1 when A < B + Bin (unsigned)
//   busy       high in RUN or DONE
//   ovf        signed overflow (only with SUB_OVF_EN)
// -----------------------------------------------------------------------------
module serial_ripple_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] d,
   output logic             bout,
`ifdef SUB_OVF_EN
   output logic             ovf,
`endif
   output logic             busy
);

   localparam int            CW   = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q,   cnt_d;
   logic             br_q,    br_d;
   logic [WIDTH-1:0] a_q,     a_d;
   logic [WIDTH-1:0] b_q,     b_d;
   logic [WIDTH-1:0] res_q,   res_d;
   logic             bout_q,  bout_d;
`ifdef SUB_OVF_EN
   logic             ovf_q,   ovf_d;
`endif

   // One full-subtractor cell. The operand registers shift right each RUN
   // cycle, so the bit being processed is always at position 0.
   logic diff_bit;
   logic br_next;

   assign diff_bit = a_q[0] ^ b_q[0] ^ br_q;
   assign br_next  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

   always_comb begin
      // NOTE: every signal gets its hold value first so no path through the
      // case statement leaves one unassigned, which would infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      br_d    = br_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      bout_d  = bout_q;
`ifdef SUB_OVF_EN
      ovf_d   = ovf_q;
`endif

      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               br_d    = bin;
               cnt_d   = '0;
               res_d   = '0;
               bout_d  = 1'b0;
`ifdef SUB_OVF_EN
               ovf_d   = 1'b0;
`endif
               state_d = S_RUN;
            end
         end

         S_RUN: begin
            // New bit enters at the MSB; after WIDTH shifts bit 0 sits in d[0].
            res_d = {diff_bit, res_q[WIDTH-1:1]};
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            br_d  = br_next;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               bout_d  = br_next;
`ifdef SUB_OVF_EN
               // a_q[0]/b_q[0] are the original sign bits on this last edge,
               // and diff_bit is the result sign bit.
               ovf_d   = (a_q[0] ^ b_q[0]) & (diff_bit ^ a_q[0]);
`endif
               state_d = S_DONE;
            end
         end

         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         br_q    <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         bout_q  <= 1'b0;
`ifdef SUB_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values, independent of statement order.
         state_q <= state_d;
         cnt_q   <= cnt_d;
         br_q    <= br_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         bout_q  <= bout_d;
`ifdef SUB_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);
   assign d         = res_q;
   assign bout      = bout_q;
`ifdef SUB_OVF_EN
   assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_ripple_subtractor
//
// Self-checking bench for serial_ripple_subtractor at WIDTH = 4. Expected
// results are pushed to a scoreboard queue when operands are driven and popped
// when the DUT presents out_valid. Table-driven vectors, random vectors against
// an arithmetic model, and hand-written backpressure and reset sequences.
// -----------------------------------------------------------------------------
module tb_serial_ripple_subtractor;

   localparam int W     = 4;
   localparam int LIMIT = 40;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] d;
   logic         bout;
   logic         busy;
`ifdef SUB_OVF_EN
   logic         ovf;
`endif

   serial_ripple_subtractor #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .d         (d),
      .bout      (bout),
`ifdef SUB_OVF_EN
      .ovf       (ovf),
`endif
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] d;
      logic         bout;
      logic         ovf;
   } exp_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         bin;
      exp_t         e;
   } vec_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
      logic [W:0] r;
      exp_t       e;
      r      = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
      e.d    = r[W-1:0];
      e.bout = r[W];
      e.ovf  = (ma[W-1] ^ mb[W-1]) & (r[W-1] ^ ma[W-1]);
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Counts edges until out_valid rises; returns the count.
   task automatic wait_result(output int n);
      n = 0;
      while (!out_valid && n < LIMIT) begin
         tick();
         n++;
      end
      check("out_valid_seen", out_valid, 1);
   endtask

   task automatic pop_compare();
      exp_t e;
      if (sb_q.size() == 0) begin
         check("scoreboard_nonempty", 0, 1);
      end else begin
         e = sb_q.pop_front();
         check("d", d, e.d);
         check("bout", bout, e.bout);
`ifdef SUB_OVF_EN
         check("ovf", ovf, e.ovf);
`endif
      end
   endtask

   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                         input exp_t e);
      int n;
      n = 0;
      while (!in_ready && n < LIMIT) begin
         tick();
         n++;
      end
      check("in_ready_idle", in_ready, 1);
      sb_q.push_back(e);
      a        = ta;
      b        = tb_v;
      bin      = tbin;
      in_valid = 1'b1;
      tick();
      // Scramble inputs after acceptance; the registered operands must win.
      in_valid = 1'b0;
      a        = ~ta;
      b        = ~tb_v;
      bin      = ~tbin;
      check("busy_run", busy, 1);
      check("in_ready_run", in_ready, 0);
      wait_result(n);
      check("latency", n, W);
      pop_compare();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("out_valid_drop", out_valid, 0);
      check("in_ready_after", in_ready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[6];
      int   n;
      logic [W-1:0] ra, rb;
      logic         rbin;

      vecs[0] = '{a: 4'b1001, b: 4'b1001, bin: 1'b0, e: '{d: 4'b0000, bout: 1'b0, ovf: 1'b0}};
      vecs[1] = '{a: 4'b1101, b: 4'b1001, bin: 1'b1, e: '{d: 4'b0011, bout: 1'b0, ovf: 1'b0}};
      vecs[2] = '{a: 4'b0111, b: 4'b1101, bin: 1'b0, e: '{d: 4'b1010, bout: 1'b1, ovf: 1'b1}};
      vecs[3] = '{a: 4'b0000, b: 4'b0000, bin: 1'b1, e: '{d: 4'b1111, bout: 1'b1, ovf: 1'b0}};
      vecs[4] = '{a: 4'b1000, b: 4'b0001, bin: 1'b0, e: '{d: 4'b0111, bout: 1'b0, ovf: 1'b1}};
      vecs[5] = '{a: 4'b1111, b: 4'b1111, bin: 1'b1, e: '{d: 4'b1111, bout: 1'b1, ovf: 1'b0}};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      bin       = 1'b0;

      #13;
      check("rst_d", d, 0);
      check("rst_bout", bout, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 1);
`ifdef SUB_OVF_EN
      check("rst_ovf", ovf, 0);
`endif
      #10 rst_n = 1'b1;
      tick();

      for (int i = 0; i < 6; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].e);
      end

      for (int i = 0; i < 8; i++) begin
         ra   = W'($urandom_range(0, (1 << W) - 1));
         rb   = W'($urandom_range(0, (1 << W) - 1));
         rbin = 1'($urandom_range(0, 1));
         run_op(ra, rb, rbin, model(ra, rb, rbin));
      end

      // Backpressure: hold DONE for 3 cycles while in_valid pulses.
      sb_q.push_back(model(4'd3, 4'd1, 1'b0));
      a = 4'd3; b = 4'd1; bin = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      wait_result(n);
      for (int i = 0; i < 3; i++) begin
         a = 4'hF; b = 4'h0; bin = 1'b0; in_valid = 1'b1;
         tick();
         check("bp_d_hold", d, 4'd2);
         check("bp_bout_hold", bout, 0);
         check("bp_in_ready", in_ready, 0);
         check("bp_out_valid", out_valid, 1);
      end
      pop_compare();
      a = 4'd9; b = 4'd4; bin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("bp_idle_in_ready", in_ready, 1);
      check("bp_idle_out_valid", out_valid, 0);
      sb_q.push_back(model(4'd9, 4'd4, 1'b0));
      tick();
      in_valid = 1'b0;
      check("bp_accept_busy", busy, 1);
      wait_result(n);
      check("bp_latency", n, W);
      check("bp_new_d", d, 4'd5);
      pop_compare();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // Reset two cycles into RUN.
      a = 4'hF; b = 4'h1; bin = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      check("pre_rst_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_d", d, 0);
      check("mid_rst_bout", bout, 0);
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_in_ready", in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("post_rst_in_ready", in_ready, 1);
      run_op(4'b0101, 4'b0011, 1'b0, '{d: 4'b0010, bout: 1'b0, ovf: 1'b0});

      check("scoreboard_empty", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/serial_ripple_subtractor.md
Name: serial_ripple_subtractor

Overview:
- Bit-serial subtractor. Computes D = A - B - Bin one bit per clock, LSB first, with a single borrow flip-flop. It is the sequential, borrow-propagating counterpart of the team's combinational ripple-carry adder.
- Sits behind a valid/ready input port and a valid/ready output port so it can drop into datapaths that already use the adder's operand format: A, B and a 1-bit carry/borrow-in.

Parameters:
- WIDTH, 4, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous reset, active-low.
- in_valid  input  1  operands a, b, bin valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- out_valid  output  1  d, bout valid.
- out_ready  input  1  consumer accepts the result.
- d  output  WIDTH  difference.
- bout  output  1  borrow-out (1 when A < B + Bin, unsigned).
- busy  output  1  high in RUN or DONE.
- ovf  output  1  signed overflow; present only with SUB_OVF_EN.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset: state = IDLE, bit counter = 0, borrow reg = 0, operand and result regs = 0.
  - Outputs during and after reset: d = 0, bout = 0, out_valid = 0, busy = 0, ovf = 0.
  - in_ready = 1, since it is decoded from the IDLE state.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready = 1. On a clock edge with in_valid & in_ready, latch a, b and bin (bin goes into the borrow reg), clear the counter, clear the result reg, go to RUN.
  - RUN: in_ready = 0. Each edge processes bit i = counter:
    - d_i = a_i ^ b_i ^ br.
    - br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
    - d_i is shifted into the result MSB side, so after WIDTH shifts bit 0 sits in d[0].
    - counter increments.
    - On the edge that processes bit WIDTH-1, go to DONE.
  - DONE: out_valid = 1; d and bout = final borrow are held stable. On an edge with out_ready = 1, go to IDLE and drop out_valid.
- Latency: operands accepted at edge 0 give out_valid high after edge WIDTH, i.e. exactly WIDTH cycles later.
- Throughput: one result per WIDTH + 2 cycles minimum (accept, WIDTH bit cycles, handshake).
- Result register updates only in RUN. While out_valid is high and out_ready is low, d, bout and ovf do not change.
- in_valid outside IDLE is ignored; no operand is captured, lost or queued.
- Input changes after acceptance do not affect the result, because operands are registered.
- Counter is ceil(log2(WIDTH)) + 1 bits and never wraps inside an operation.
- Arithmetic is modulo 2^WIDTH, e.g. 0 - 0 - 1 gives all ones with bout = 1.
- Reset asserted mid-RUN or mid-DONE returns to the reset values immediately. The partial result is discarded, and after release the block is in IDLE with in_ready = 1.
- out_ready while in IDLE or RUN has no effect.

Optional Feature:
- Macro: SUB_OVF_EN.
- Defined: port ovf exists, registered on entry to DONE as ovf = (a[WIDTH-1] ^ b[WIDTH-1]) & (d[WIDTH-1] ^ a[WIDTH-1]), treating bin as part of the subtrahend. It is held with d and reset to 0.
- Undefined: ovf port and its logic are absent; everything else is identical.

Test Plan (WIDTH = 4):
- a=1001, b=1001, bin=0 -> d=0000, bout=0, out_valid exactly 4 cycles after the accept edge.
- a=1101, b=1001, bin=1 -> d=0011, bout=0.
- a=0111, b=1101, bin=0 -> d=1010, bout=1, and ovf=1 when SUB_OVF_EN is defined.
- a=0000, b=0000, bin=1 -> d=1111, bout=1 (wrap), and ovf=0 when SUB_OVF_EN is defined.
- Backpressure: hold out_ready=0 for 3 cycles in DONE and pulse in_valid with new operands -> d and bout stable, in_ready=0, new operands not captured. out_ready=1 -> IDLE next edge, then the new operands are accepted.
- Reset: assert rst_n=0 two cycles into RUN -> d=0, bout=0, out_valid=0, busy=0 immediately. After release in_ready=1, and a fresh a=0101, b=0011, bin=0 yields d=0010, bout=0.
